// File: rtl/grf_scoreboard.sv
// GRF hazard scoreboard: per-register in-flight writer count and Tnew countdown,
// producing D-stage stall and forward-ready flags for the 5-stage pipeline.
module grf_scoreboard #(
  parameter int NREG  = 32,
  parameter int TW    = 2,
  parameter int DEPTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rs,
  input  logic [4:0]    issue_rt,
  input  logic [TW-1:0] tuse_rs,
  input  logic [TW-1:0] tuse_rt,
  input  logic          issue_wen,
  input  logic [4:0]    issue_dst,
  input  logic [TW-1:0] issue_tnew,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  output logic          stall,
  output logic          fwd_rs,
  output logic          fwd_rt,
  output logic          sb_err
);

  localparam int IW = $clog2(DEPTH + 1);

  logic [IW-1:0] inflight_q [NREG];
  logic [IW-1:0] inflight_d [NREG];
  logic [TW-1:0] cnt_q [NREG];
  logic [TW-1:0] cnt_d [NREG];
  logic          sb_err_q, sb_err_d;
  logic          pend_rs, pend_rt, hz_rs, hz_rt;
  logic          alloc, retire;

  // Lookups use pre-update state, so a self-dependency (rs == dst) sees the older writer.
  always_comb begin
    pend_rs = (issue_rs != 5'd0) && (inflight_q[issue_rs] != '0);
    pend_rt = (issue_rt != 5'd0) && (inflight_q[issue_rt] != '0);
    hz_rs   = issue_valid && pend_rs && (cnt_q[issue_rs] > tuse_rs);
    hz_rt   = issue_valid && pend_rt && (cnt_q[issue_rt] > tuse_rt);
    stall   = hz_rs || hz_rt;
    fwd_rs  = issue_valid && pend_rs && (cnt_q[issue_rs] == '0);
    fwd_rt  = issue_valid && pend_rt && (cnt_q[issue_rt] == '0);
    alloc   = issue_valid && !stall && issue_wen && (issue_dst != 5'd0);
    retire  = wb_we && (wb_addr != 5'd0);
  end

  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      inflight_d[r] = inflight_q[r];
      cnt_d[r]      = (cnt_q[r] != '0) ? cnt_q[r] - TW'(1) : cnt_q[r];
      if (r == 0) begin
        inflight_d[r] = '0;
        cnt_d[r]      = '0;
      end else begin
        if (alloc && (issue_dst == 5'(r)) && retire && (wb_addr == 5'(r))) begin
          // Oldest writer retires as a new one enters: count unchanged.
          if (inflight_q[r] == '0) sb_err_d = 1'b1;
          cnt_d[r] = issue_tnew;
        end else if (alloc && (issue_dst == 5'(r))) begin
          if (inflight_q[r] == IW'(DEPTH)) begin
            sb_err_d = 1'b1;
          end else begin
            inflight_d[r] = inflight_q[r] + IW'(1);
            cnt_d[r]      = issue_tnew;
          end
        end else if (retire && (wb_addr == 5'(r))) begin
          if (inflight_q[r] == '0) sb_err_d = 1'b1;
          else inflight_d[r] = inflight_q[r] - IW'(1);
        end
        if (inflight_d[r] == '0) cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        inflight_q[r] <= '0;
        cnt_q[r]      <= '0;
      end
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        inflight_q[r] <= '0;
        cnt_q[r]      <= '0;
      end
    end else begin
      sb_err_q <= sb_err_d;
      for (int r = 0; r < NREG; r++) begin
        inflight_q[r] <= inflight_d[r];
        cnt_q[r]      <= cnt_d[r];
      end
    end
  end

  assign sb_err = sb_err_q;

endmodule
